// File: rtl/speicher_zugriff.sv
// Initiator-side controller for the word RAM strobe/acknowledge protocol.
// One read or write in flight; strobe held until ack, then waits for ack to fall.
module speicher_zugriff #(
  parameter int WORDSIZE = 32,
  parameter int WORDS    = 32,
  parameter int TIMEOUT  = 16,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Anfrage,
  input  logic                Schreiben,
  input  logic [AW-1:0]       AdresseRein,
  input  logic [WORDSIZE-1:0] DatenSchreiben,
  output logic                Bereit,
  output logic                Fertig,
  output logic                Fehler,
  output logic [WORDSIZE-1:0] DatenGelesen,
  output logic                RamLesenAn,
  output logic                RamSchreibenAn,
  output logic [AW-1:0]       RamAdresse,
  output logic [WORDSIZE-1:0] RamDatenRein,
  input  logic [WORDSIZE-1:0] RamDatenRaus,
  input  logic                RamDatenBereit,
  input  logic                RamDatenGeschrieben,
  output logic [1:0]          state_dbg
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ANFRAGE   = 2'd1,
    ABSCHLUSS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lesen_q, lesen_d;
  logic                  schreiben_q, schreiben_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [WORDSIZE-1:0]   wdata_q, wdata_d;
  logic [WORDSIZE-1:0]   rdata_q, rdata_d;
  logic                  fertig_q, fertig_d;
  logic                  fehler_q, fehler_d;
  logic                  ack;

  // A stale ack from an aborted or reset access must fall before a new request.
  assign Bereit = (state_q == IDLE) & ~RamDatenBereit & ~RamDatenGeschrieben;

  // wr_q remembers the operation after the strobes drop, so ABSCHLUSS watches the right ack.
  assign ack = wr_q ? RamDatenGeschrieben : RamDatenBereit;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    lesen_d     = lesen_q;
    schreiben_d = schreiben_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    fertig_d    = 1'b0;
    fehler_d    = fehler_q;
    case (state_q)
      IDLE: begin
        if (Anfrage && Bereit) begin
          adr_d       = AdresseRein;
          wdata_d     = DatenSchreiben;
          wr_d        = Schreiben;
          schreiben_d = Schreiben;
          lesen_d     = ~Schreiben;
          fehler_d    = 1'b0;
          cnt_d       = '0;
          state_d     = ANFRAGE;
        end
      end
      ANFRAGE: begin
        if (ack) begin
          if (!wr_q) rdata_d = RamDatenRaus;
          lesen_d     = 1'b0;
          schreiben_d = 1'b0;
          fertig_d    = 1'b1;
          state_d     = ABSCHLUSS;
        end else if (cnt_q == CNT_MAX) begin
          lesen_d     = 1'b0;
          schreiben_d = 1'b0;
          fehler_d    = 1'b1;
          fertig_d    = 1'b1;
          state_d     = ABSCHLUSS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABSCHLUSS: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      lesen_q     <= 1'b0;
      schreiben_q <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      fertig_q    <= 1'b0;
      fehler_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      lesen_q     <= lesen_d;
      schreiben_q <= schreiben_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      fertig_q    <= fertig_d;
      fehler_q    <= fehler_d;
    end
  end

  assign Fertig         = fertig_q;
  assign Fehler         = fehler_q;
  assign DatenGelesen   = rdata_q;
  assign RamLesenAn     = lesen_q;
  assign RamSchreibenAn = schreiben_q;
  assign RamAdresse     = adr_q;
  assign RamDatenRein   = wdata_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_speicher_zugriff.sv
// Directed plus randomized bench for speicher_zugriff with a behavioural RAM and reference memory.
module tb_speicher_zugriff;

  logic        clk = 1'b0;
  logic        nReset;
  logic        Anfrage, Schreiben;
  logic [4:0]  AdresseRein;
  logic [31:0] DatenSchreiben;
  logic        Bereit, Fertig, Fehler;
  logic [31:0] DatenGelesen;
  logic        RamLesenAn, RamSchreibenAn;
  logic [4:0]  RamAdresse;
  logic [31:0] RamDatenRein;
  logic [31:0] RamDatenRaus;
  logic        RamDatenBereit, RamDatenGeschrieben;
  logic [1:0]  state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int ram_delay = 1;
  int fert_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rd;

  speicher_zugriff #(.WORDSIZE(32), .WORDS(32), .TIMEOUT(16)) dut (
    .Clock(clk), .nReset(nReset), .Anfrage(Anfrage), .Schreiben(Schreiben),
    .AdresseRein(AdresseRein), .DatenSchreiben(DatenSchreiben), .Bereit(Bereit),
    .Fertig(Fertig), .Fehler(Fehler), .DatenGelesen(DatenGelesen),
    .RamLesenAn(RamLesenAn), .RamSchreibenAn(RamSchreibenAn), .RamAdresse(RamAdresse),
    .RamDatenRein(RamDatenRein), .RamDatenRaus(RamDatenRaus),
    .RamDatenBereit(RamDatenBereit), .RamDatenGeschrieben(RamDatenGeschrieben),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_pat(input logic [4:0] a);
    if (a == 5'd3) return 32'h1234_5678;
    return {27'h0, a} * 32'h0101_0101 ^ 32'hA5A5_0000;
  endfunction

  // RAM model: ack rises ram_delay cycles after the strobe is first sampled, falls once it drops.
  logic [31:0] ram_mem [32];
  bit   [31:0] ram_valid;
  int          wait_cnt = 0;
  logic        ack_rd = 1'b0, ack_wr = 1'b0;
  logic [31:0] rd_q = '0;
  assign RamDatenBereit      = ack_rd;
  assign RamDatenGeschrieben = ack_wr;
  assign RamDatenRaus        = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (RamLesenAn || RamSchreibenAn) begin
      if (wait_cnt + 1 >= ram_delay) begin
        if (RamSchreibenAn) begin
          ram_mem[RamAdresse]   <= RamDatenRein;
          ram_valid[RamAdresse] <= 1'b1;
          ack_wr <= 1'b1;
        end else begin
          rd_q   <= ram_valid[RamAdresse] ? ram_mem[RamAdresse] : init_pat(RamAdresse);
          ack_rd <= 1'b1;
        end
      end
      wait_cnt <= wait_cnt + 1;
    end else begin
      ack_rd   <= 1'b0;
      ack_wr   <= 1'b0;
      wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Fertig) fert_q.push_back(cyc);
    if (RamLesenAn && RamSchreibenAn) check("strobe_overlap", 32'd1, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access; lat = cycles from acceptance to Fertig, rec = cycles from Fertig to Bereit.
  task automatic do_access(input logic wr, input logic [4:0] a, input logic [31:0] d,
                           input int dly, output int lat, output int rec);
    int n;
    Schreiben = wr; AdresseRein = a; DatenSchreiben = d; ram_delay = dly; Anfrage = 1'b1;
    n = 0;
    while (!Bereit && n < 50) begin tick(); n++; end
    if (!Bereit) check("wait_bereit", 32'(Bereit), 32'd1);
    tick();
    Anfrage = 1'b0;
    check("strobe_kind", {30'h0, RamSchreibenAn, RamLesenAn}, wr ? 32'd2 : 32'd1);
    check("ram_adresse", 32'(RamAdresse), 32'(a));
    check("fehler_clear", 32'(Fehler), 32'd0);
    lat = 0;
    while (!Fertig && lat < 40) begin
      tick(); lat++;
      if (!Fertig && !(RamLesenAn | RamSchreibenAn)) check("strobe_held", 32'd0, 32'd1);
    end
    check("strobe_dropped", {30'h0, RamSchreibenAn, RamLesenAn}, 32'd0);
    rec = 0;
    while (!Bereit && rec < 10) begin
      tick(); rec++;
      if (rec == 1) check("fertig_one_cycle", 32'(Fertig), 32'd0);
    end
  endtask

  int lat, rec, t0;
  logic        r_wr;
  logic [4:0]  r_a;
  logic [31:0] r_d;
  int          r_dly;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_pat(5'(i));
    exp_rd = '0;
    nReset = 1'b0; Anfrage = 1'b0; Schreiben = 1'b0; AdresseRein = '0; DatenSchreiben = '0;
    repeat (3) tick();
    check("rst_outputs", {25'h0, Fertig, Fehler, RamLesenAn, RamSchreibenAn, RamAdresse == 5'd0,
                          RamDatenRein == 32'd0, DatenGelesen == 32'd0}, 32'h7);
    nReset = 1'b1;
    tick();
    check("rst_bereit", 32'(Bereit), 32'd1);

    // Plain read of word 3
    do_access(1'b0, 5'd3, 32'h0, 1, lat, rec);
    check("read_lat", lat, 2);
    check("read_rec", rec, 2);
    check("read_data", DatenGelesen, 32'h1234_5678);
    exp_rd = 32'h1234_5678;

    // Write then read back
    do_access(1'b1, 5'd7, 32'hDEAD_BEEF, 1, lat, rec);
    ref_mem[7] = 32'hDEAD_BEEF;
    check("write_lat", lat, 2);
    check("write_keeps_rd", DatenGelesen, exp_rd);
    do_access(1'b0, 5'd7, 32'h0, 1, lat, rec);
    check("readback", DatenGelesen, 32'hDEAD_BEEF);
    check("readback_fehler", 32'(Fehler), 32'd0);
    exp_rd = 32'hDEAD_BEEF;

    // Back-to-back with Anfrage held: read 0, write 1, read 2
    fert_q.delete();
    ram_delay = 1;
    Anfrage = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      Schreiben = (k == 1); AdresseRein = 5'(k); DatenSchreiben = 32'hC0DE_0000 + k;
      n = 0;
      while (!Bereit && n < 50) begin tick(); n++; end
      tick();
    end
    Anfrage = 1'b0;
    ref_mem[1] = 32'hC0DE_0001;
    repeat (6) tick();
    check("b2b_count", fert_q.size(), 3);
    if (fert_q.size() == 3) begin
      check("b2b_gap1", fert_q[1] - fert_q[0], 5);
      check("b2b_gap2", fert_q[2] - fert_q[1], 5);
    end
    check("b2b_data", DatenGelesen, ref_mem[2]);
    exp_rd = ref_mem[2];

    // Timeout: RAM never answers
    do_access(1'b0, 5'd9, 32'h0, 1000, lat, rec);
    check("to_lat", lat, 16);
    check("to_fehler", 32'(Fehler), 32'd1);
    check("to_data_kept", DatenGelesen, exp_rd);
    check("to_rec", rec, 1);
    do_access(1'b0, 5'd9, 32'h0, 1, lat, rec);
    check("to_cleared", 32'(Fehler), 32'd0);
    check("to_next_data", DatenGelesen, ref_mem[9]);
    exp_rd = ref_mem[9];

    // Reset one cycle after acceptance, while the read ack rises
    Schreiben = 1'b0; AdresseRein = 5'd5; ram_delay = 1; Anfrage = 1'b1;
    tick();
    Anfrage = 1'b0;
    nReset = 1'b0;
    tick();
    check("midrst_outputs", {26'h0, Fertig, Fehler, RamLesenAn, RamSchreibenAn,
                             RamAdresse != 5'd0, DatenGelesen != 32'd0}, 32'd0);
    check("midrst_bereit_blocked", 32'(Bereit), 32'd0);
    nReset = 1'b1;
    tick();
    check("midrst_bereit_back", 32'(Bereit), 32'd1);
    do_access(1'b0, 5'd5, 32'h0, 1, lat, rec);
    check("midrst_data", DatenGelesen, ref_mem[5]);
    exp_rd = ref_mem[5];

    // Slow RAM
    do_access(1'b0, 5'd3, 32'h0, 5, lat, rec);
    check("slow_lat", lat, 6);
    check("slow_data", DatenGelesen, ref_mem[3]);
    check("slow_fehler", 32'(Fehler), 32'd0);
    exp_rd = ref_mem[3];

    // Randomized accesses
    for (int i = 0; i < 25; i++) begin
      r_wr  = 1'($urandom_range(0, 1));
      r_a   = 5'($urandom_range(0, 31));
      r_d   = $urandom;
      r_dly = $urandom_range(1, 6);
      if (!r_wr) exp_q.push_back(ref_mem[r_a]);
      else ref_mem[r_a] = r_d;
      do_access(r_wr, r_a, r_d, r_dly, lat, rec);
      check("rnd_lat", lat, r_dly + 1);
      check("rnd_fehler", 32'(Fehler), 32'd0);
      if (!r_wr) exp_rd = exp_q.pop_front();
      check("rnd_data", DatenGelesen, exp_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/speicher_zugriff.md
Name: speicher_zugriff

Overview:
- Initiator-side memory access controller: the processor's load/store/fetch unit drives this block, which drives the word RAM's LesenAn/SchreibenAn strobe and acknowledge protocol.
- Accepts one read or write request at a time.
- Holds the strobe until the RAM acknowledges, then waits for the acknowledge to fall.
- Returns read data with a one-cycle Fertig pulse; a timeout counter flags a RAM that never answers.

Parameters:
WORDSIZE, 32, data word width
WORDS, 32, RAM depth; address width = $clog2(WORDS)
TIMEOUT, 16, max cycles in ANFRAGE before abort (>=2)

Ports:
Clock  in  1  system clock, all logic on rising edge
nReset  in  1  synchronous, active-low reset
Anfrage  in  1  request from processor; sampled only while Bereit=1
Schreiben  in  1  1=write, 0=read; sampled with Anfrage
AdresseRein  in  $clog2(WORDS)  word address; sampled with Anfrage
DatenSchreiben  in  WORDSIZE  write data; sampled with Anfrage
Bereit  out  1  block can accept a request this cycle
Fertig  out  1  one-cycle pulse: access finished (or aborted)
Fehler  out  1  last access timed out; sticky until next accepted request
DatenGelesen  out  WORDSIZE  read result, valid from Fertig onward until next read completes
RamLesenAn  out  1  to RAM LesenAn
RamSchreibenAn  out  1  to RAM SchreibenAn
RamAdresse  out  $clog2(WORDS)  to RAM Adresse
RamDatenRein  out  WORDSIZE  to RAM DatenRein
RamDatenRaus  in  WORDSIZE  from RAM DatenRaus
RamDatenBereit  in  1  RAM read acknowledge
RamDatenGeschrieben  in  1  RAM write acknowledge

Behaviour:
- Reset (nReset=0 at a rising edge): state IDLE; RamLesenAn=0, RamSchreibenAn=0, RamAdresse=0, RamDatenRein=0, Fertig=0, Fehler=0, DatenGelesen=0, timeout counter=0.
- Reset mid-access drops the strobe immediately (next edge).
- All outputs are registered except Bereit.
- Bereit = (state==IDLE) & !RamDatenBereit & !RamDatenGeschrieben. This blocks a new access while a stale ack from an aborted or reset access is still high.
- Acceptance: edge where Anfrage=1 and Bereit=1. Then:
  - latch AdresseRein into RamAdresse and DatenSchreiben into RamDatenRein;
  - set RamSchreibenAn=Schreiben, RamLesenAn=!Schreiben;
  - Fehler<=0, counter<=0, state<=ANFRAGE.
- Anfrage while Bereit=0 is ignored; the requester holds Anfrage until accepted.
- ANFRAGE:
  - Relevant ack = RamDatenGeschrieben for write, RamDatenBereit for read; the other ack is ignored.
  - Relevant ack=1: on a read, DatenGelesen<=RamDatenRaus. Then drop both strobes, Fertig<=1, state<=ABSCHLUSS.
  - Else if counter==TIMEOUT-1: drop both strobes, Fehler<=1, Fertig<=1, state<=ABSCHLUSS. DatenGelesen is unchanged.
  - Else counter<=counter+1; strobe stays high.
- ABSCHLUSS: Fertig<=0. State<=IDLE at the first edge where the relevant ack is sampled 0.
- Timing with the standard RAM (acks one cycle after the sampled strobe), acceptance at edge E0:
  - E0: strobe rises.
  - E1: RAM acks.
  - E2: Fertig=1, data latched, strobe low.
  - E3: ack falls.
  - E4: IDLE.
  - Earliest next acceptance at E5.
  - Fertig is high exactly one cycle. A read completes 2 cycles after acceptance; throughput is one access per 5 cycles.
- RamAdresse/RamDatenRein stay stable from acceptance until the next acceptance.
- Never assert RamLesenAn and RamSchreibenAn together.

Test Plan:
- Read: RAM word 3=32'h12345678; Anfrage=1, Schreiben=0, AdresseRein=3 at E0 -> RamLesenAn high E0..E2, Fertig single pulse after E2, DatenGelesen=32'h12345678, Bereit low E0..E4 and high again after E4.
- Write then read back: write 32'hDEADBEEF to address 7, then read address 7 -> RamSchreibenAn only during write, Fertig twice, DatenGelesen=32'hDEADBEEF, Fehler=0.
- Back-to-back requests: Anfrage held high for 3 accesses (read 0, write 1, read 2) -> each accepted only when Bereit=1; strobes never overlap; 3 Fertig pulses spaced 5 cycles apart.
- Timeout: RAM model never acks, TIMEOUT=16 -> strobe high 16 cycles, then Fertig=1 and Fehler=1. DatenGelesen is unchanged. Block returns to IDLE one cycle later. Next accepted request clears Fehler.
- Reset mid-read: nReset=0 one cycle after acceptance while RAM ack rises -> all outputs 0 after that edge. Bereit stays 0 while RamDatenBereit=1. The next request is accepted only after the ack falls, and its returned data is correct.
- Slow RAM: ack delayed 5 cycles -> Fertig 6 cycles after acceptance, correct data, no Fehler.
